// File: rtl/adxl357_pkg.sv
// Shared definitions for the ADXL357 I2C controller and its sequencer.
// Control/status bit map, op codes, register map and sequencer states.
package adxl357_pkg;

  localparam logic [2:0] OP_CPU_WREG = 3'd1;
  localparam logic [2:0] OP_HW       = 3'd4;

  localparam logic [2:0] RATE_SLOW = 3'd0;
  localparam logic [2:0] RATE_FAST = 3'd7;

  localparam int CTRL_EN_BIT   = 0;
  localparam int CTRL_OP_LSB   = 1;
  localparam int CTRL_RATE_LSB = 4;

  localparam int STAT_FINISH_BIT = 1;
  localparam int STAT_STATE_LSB  = 2;
  localparam int STAT_SME_BIT    = 10;

  localparam logic [7:0] REG_FILTER    = 8'h28;
  localparam logic [7:0] REG_RANGE     = 8'h2C;
  localparam logic [7:0] REG_POWER_CTL = 8'h2D;

  typedef enum logic [2:0] {
    ST_STARTUP,
    ST_ARM,
    ST_WAIT,
    ST_RELEASE,
    ST_HW_RUN,
    ST_FAIL,
    ST_QUIESCE
  } seq_state_e;

  typedef struct packed {
    logic [24:0] rsvd;
    logic [2:0]  clk_rate;
    logic [2:0]  op_mode;
    logic        en;
  } ctrl_t;

  function automatic ctrl_t mk_ctrl(
    input logic [2:0] rate,
    input logic [2:0] op,
    input logic       en
  );
    ctrl_t c;
    c          = '0;
    c.clk_rate = rate;
    c.op_mode  = op;
    c.en       = en;
    return c;
  endfunction

endpackage

// File: rtl/adxl357_init_sequencer_sync.sv
// Two-flop synchroniser for single-bit levels from the I2C clock domain.
// Reset clears both stages so downstream edge detectors start idle.
module sync_2ff (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic d,
  output logic q
);

  logic meta;

  // two-stage capture of an asynchronous level
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      meta <= 1'b0;
      q    <= 1'b0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/adxl357_init_sequencer.sv
// Power-up register write sequencer in front of the ADXL357 I2C controller.
// Writes RANGE, FILTER, POWER_CTL with retry, then hands over to HW streaming.
module adxl357_init_sequencer
  import adxl357_pkg::*;
#(
  parameter int         STARTUP_CYC = 500000,
  parameter int         TIMEOUT_CYC = 65536,
  parameter int         SETTLE_CYC  = 512,
  parameter int         MAX_RETRY   = 3,
  parameter logic [2:0] CLK_RATE    = 3'd7,
  parameter logic [7:0] W0_ADDR     = REG_RANGE,
  parameter logic [7:0] W0_DATA     = 8'h01,
  parameter logic [7:0] W1_ADDR     = REG_FILTER,
  parameter logic [7:0] W1_DATA     = 8'h00,
  parameter logic [7:0] W2_ADDR     = REG_POWER_CTL,
  parameter logic [7:0] W2_DATA     = 8'h00
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_start,
  input  logic [31:0] i_status,
  output logic [31:0] o_ctrl,
  output logic [7:0]  o_reg_addr,
  output logic [7:0]  o_w_data,
  output logic        o_busy,
  output logic        o_done,
  output logic        o_error,
  output logic [1:0]  o_step
);

  localparam int RW = (MAX_RETRY < 1) ? 1 : $clog2(MAX_RETRY + 1);
  localparam logic [RW-1:0] RMAX = RW'(MAX_RETRY);
  localparam logic [31:0] STARTUP_LAST = 32'(STARTUP_CYC - 1);
  localparam logic [31:0] TIMEOUT_LAST = 32'(TIMEOUT_CYC - 1);
  localparam logic [31:0] SETTLE_LAST  = 32'(SETTLE_CYC - 1);

  seq_state_e    state_q, state_d;
  ctrl_t         ctrl_q, ctrl_d;
  logic [7:0]    addr_q, addr_d;
  logic [7:0]    data_q, data_d;
  logic [7:0]    wr_addr, wr_data;
  logic [1:0]    step_q, step_d;
  logic [RW-1:0] rcnt_q, rcnt_d;
  logic          retry_q, retry_d;
  logic          qph_q, qph_d;
  logic [31:0]   cnt_q, cnt_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic          err_q, err_d;

  logic fin_s, sme_s, fin_q, sme_q;
  logic fin_rise, sme_fall, timeout, settled;
  logic unused_status;

  assign unused_status = ^{i_status[31:11],
                           i_status[9:2],
                           i_status[0]};

  sync_2ff u_sync_fin (
    .i_clk  (i_clk),
    .i_rst_n(i_rst_n),
    .d      (i_status[STAT_FINISH_BIT]),
    .q      (fin_s)
  );

  sync_2ff u_sync_sme (
    .i_clk  (i_clk),
    .i_rst_n(i_rst_n),
    .d      (i_status[STAT_SME_BIT]),
    .q      (sme_s)
  );

  assign fin_rise = fin_s & ~fin_q;
  assign sme_fall = ~sme_s & sme_q;
  assign timeout  = (cnt_q == TIMEOUT_LAST);
  assign settled  = ~sme_s && (cnt_q == SETTLE_LAST);

  assign o_ctrl     = ctrl_q;
  assign o_reg_addr = addr_q;
  assign o_w_data   = data_q;
  assign o_busy     = busy_q;
  assign o_done     = done_q;
  assign o_error    = err_q;
  assign o_step     = step_q;

  // register address/data for the current step
  always_comb begin
    wr_addr = W2_ADDR;
    wr_data = W2_DATA;
    unique case (step_q)
      2'd0: begin
        wr_addr = W0_ADDR;
        wr_data = W0_DATA;
      end
      2'd1: begin
        wr_addr = W1_ADDR;
        wr_data = W1_DATA;
      end
      default: ;
    endcase
  end

  // state and all registered outputs
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= ST_STARTUP;
      ctrl_q  <= '0;
      addr_q  <= '0;
      data_q  <= '0;
      step_q  <= '0;
      rcnt_q  <= '0;
      retry_q <= 1'b0;
      qph_q   <= 1'b0;
      cnt_q   <= '0;
      busy_q  <= 1'b1;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      fin_q   <= 1'b0;
      sme_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      ctrl_q  <= ctrl_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      step_q  <= step_d;
      rcnt_q  <= rcnt_d;
      retry_q <= retry_d;
      qph_q   <= qph_d;
      cnt_q   <= cnt_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      err_q   <= err_d;
      fin_q   <= fin_s;
      sme_q   <= sme_s;
    end
  end

  // next-state selection
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_STARTUP:
        if (cnt_q == STARTUP_LAST) state_d = ST_ARM;
      ST_ARM:
        state_d = ST_WAIT;
      ST_WAIT:
        if (fin_rise || sme_fall || timeout)
          state_d = ST_RELEASE;
      ST_RELEASE:
        if (settled) begin
          if (retry_q)
            state_d = (rcnt_q < RMAX) ? ST_ARM : ST_FAIL;
          else
            state_d = (step_q == 2'd2) ? ST_HW_RUN : ST_ARM;
        end
      ST_HW_RUN:
        if (i_start) state_d = ST_QUIESCE;
      ST_FAIL:
        if (i_start) state_d = ST_ARM;
      ST_QUIESCE:
        if (qph_q && settled) state_d = ST_ARM;
      default:
        state_d = ST_STARTUP;
    endcase
  end

  // datapath and output updates for the chosen transition
  always_comb begin
    ctrl_d  = ctrl_q;
    addr_d  = addr_q;
    data_d  = data_q;
    step_d  = step_q;
    rcnt_d  = rcnt_q;
    retry_d = retry_q;
    qph_d   = qph_q;
    cnt_d   = cnt_q + 32'd1;
    unique case (state_q)
      ST_ARM: begin
        addr_d  = wr_addr;
        data_d  = wr_data;
        ctrl_d  = mk_ctrl(CLK_RATE, OP_CPU_WREG, 1'b1);
        retry_d = 1'b0;
      end
      ST_WAIT: begin
        if (fin_rise) begin
          ctrl_d.en = 1'b0;
        end else if (sme_fall || timeout) begin
          ctrl_d.en = 1'b0;
          retry_d   = 1'b1;
        end
      end
      ST_RELEASE: begin
        if (sme_s) cnt_d = '0;
        if (settled) begin
          if (retry_q) begin
            if (rcnt_q < RMAX)
              rcnt_d = rcnt_q + 1'b1;
            else
              ctrl_d = mk_ctrl(CLK_RATE, OP_CPU_WREG, 1'b0);
          end else if (step_q != 2'd2) begin
            step_d = step_q + 2'd1;
            rcnt_d = '0;
          end else begin
            ctrl_d = mk_ctrl(CLK_RATE, OP_HW, 1'b0);
          end
        end
      end
      ST_HW_RUN: begin
        if (i_start) begin
          ctrl_d = mk_ctrl(CLK_RATE, OP_HW, 1'b0);
          qph_d  = 1'b0;
        end
      end
      ST_FAIL: begin
        if (i_start) begin
          step_d = '0;
          rcnt_d = '0;
        end
      end
      ST_QUIESCE: begin
        if (!qph_q) begin
          cnt_d = '0;
          if (!sme_s) begin
            qph_d  = 1'b1;
            ctrl_d = mk_ctrl(CLK_RATE, OP_CPU_WREG, 1'b0);
          end
        end else begin
          if (sme_s) cnt_d = '0;
          if (settled) begin
            step_d = '0;
            rcnt_d = '0;
          end
        end
      end
      default: ;
    endcase
    if (state_d != state_q) cnt_d = '0;
    busy_d = !(state_d inside {ST_HW_RUN, ST_FAIL});
    done_d = (state_d == ST_HW_RUN);
    err_d  = (state_d == ST_FAIL);
  end

endmodule

// File: tb/tb_adxl357_init_sequencer.sv
// Directed bench for adxl357_init_sequencer with an inline controller model.
// Covers nominal, NACK retry, timeout/FAIL, enable release, re-init, reset.
module tb_adxl357_init_sequencer;

  localparam int K_ACK    = 0;
  localparam int K_NACK   = 1;
  localparam int K_NORESP = 2;
  localparam int K_LONG   = 3;
  localparam int K_SIMUL  = 4;

  localparam logic [31:0] CTRL_FAIL = 32'h0000_0072;
  localparam logic [31:0] CTRL_HW   = 32'h0000_0078;

  logic        clk   = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        fin   = 1'b0;
  logic        sme   = 1'b0;
  logic [31:0] status;
  logic [31:0] o_ctrl;
  logic [7:0]  o_reg_addr;
  logic [7:0]  o_w_data;
  logic        o_busy;
  logic        o_done;
  logic        o_error;
  logic [1:0]  o_step;

  int n_chk = 0;
  int n_err = 0;

  assign status = {21'd0, sme, 8'h5A, fin, 1'b0};

  always #5 clk = ~clk;

  adxl357_init_sequencer #(
    .STARTUP_CYC(100),
    .TIMEOUT_CYC(200),
    .SETTLE_CYC (16),
    .MAX_RETRY  (3)
  ) dut (
    .i_clk     (clk),
    .i_rst_n   (rst_n),
    .i_start   (start),
    .i_status  (status),
    .o_ctrl    (o_ctrl),
    .o_reg_addr(o_reg_addr),
    .o_w_data  (o_w_data),
    .o_busy    (o_busy),
    .o_done    (o_done),
    .o_error   (o_error),
    .o_step    (o_step)
  );

  task automatic check(
    input string       tag,
    input logic [63:0] obs,
    input logic [63:0] exp
  );
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h",
             tag, obs, exp);
    end
  endtask

  task automatic wait_en(input int lim, output int k);
    k = 0;
    while (!o_ctrl[0] && k < lim) begin
      @(negedge clk);
      k++;
    end
  endtask

  task automatic wait_drop(output int k);
    k = 0;
    while (o_ctrl[0] && k < 400) begin
      @(negedge clk);
      k++;
    end
  endtask

  task automatic startup_chk(input string tag);
    int k;
    wait_en(1000, k);
    check(tag, 64'(k), 64'd101);
  endtask

  task automatic hw_chk(input string tag);
    int k;
    k = 0;
    while (!o_done && k < 200) begin
      @(negedge clk);
      k++;
    end
    check(tag, 64'({o_ctrl, o_busy, o_done, o_error}),
          64'({CTRL_HW, 3'b010}));
  endtask

  task automatic start_pulse();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  // one write as seen by the controller model
  task automatic txn(
    input int         kind,
    input logic [1:0] es,
    input logic [7:0] ea,
    input logic [7:0] ed,
    input string      tag
  );
    int k;
    int hi;
    wait_en(2000, k);
    check({tag, " arm"}, 64'(o_ctrl[0]), 64'd1);
    if (!o_ctrl[0]) return;
    check({tag, " req"},
          64'({o_step, o_ctrl[6:0], o_reg_addr, o_w_data}),
          64'({es, 3'd7, 3'd1, 1'b1, ea, ed}));
    if (kind == K_NORESP) begin
      wait_drop(k);
      check({tag, " tmo"}, 64'(k), 64'd200);
      return;
    end
    repeat (3) @(negedge clk);
    sme = 1'b1;
    repeat (20) @(negedge clk);
    if (kind == K_NACK) begin
      sme = 1'b0;
    end else if (kind == K_SIMUL) begin
      sme = 1'b0;
      fin = 1'b1;
    end else begin
      fin = 1'b1;
    end
    wait_drop(k);
    check({tag, " drop"}, 64'(k), 64'd3);
    if (kind == K_LONG) begin
      hi = 0;
      repeat (500) begin
        @(negedge clk);
        if (o_ctrl[0]) hi++;
      end
      check({tag, " rearm"}, 64'(hi), 64'd0);
    end else begin
      repeat (2) @(negedge clk);
    end
    fin = 1'b0;
    sme = 1'b0;
  endtask

  initial begin
    int k;
    int hi;

    repeat (3) @(negedge clk);
    check("rst ctrl", 64'(o_ctrl), 64'd0);
    check("rst addr", 64'(o_reg_addr), 64'd0);
    check("rst data", 64'(o_w_data), 64'd0);
    check("rst busy", 64'(o_busy), 64'd1);
    check("rst done", 64'(o_done), 64'd0);
    check("rst err", 64'(o_error), 64'd0);
    check("rst step", 64'(o_step), 64'd0);

    rst_n = 1'b1;
    startup_chk("startup 1");

    txn(K_LONG,  2'd0, 8'h2C, 8'h01, "w0 long");
    txn(K_NACK,  2'd1, 8'h28, 8'h00, "w1 nack a");
    txn(K_NACK,  2'd1, 8'h28, 8'h00, "w1 nack b");
    txn(K_ACK,   2'd1, 8'h28, 8'h00, "w1 ack");
    txn(K_SIMUL, 2'd2, 8'h2D, 8'h00, "w2 simul");
    hw_chk("hw run 1");

    sme = 1'b1;
    repeat (5) @(negedge clk);
    start_pulse();
    hi = 0;
    repeat (1000) begin
      @(negedge clk);
      if (o_ctrl[3:1] != 3'd4) hi++;
    end
    check("quiesce op hold", 64'(hi), 64'd0);
    check("quiesce busy", 64'({o_busy, o_done}), 64'b10);
    sme = 1'b0;
    k = 0;
    while (o_ctrl[3:1] != 3'd1 && k < 50) begin
      @(negedge clk);
      k++;
    end
    check("quiesce switch lat", 64'(k), 64'd3);
    check("quiesce ctrl", 64'(o_ctrl), 64'(CTRL_FAIL));

    txn(K_ACK, 2'd0, 8'h2C, 8'h01, "ri w0");
    txn(K_ACK, 2'd1, 8'h28, 8'h00, "ri w1");
    txn(K_ACK, 2'd2, 8'h2D, 8'h00, "ri w2");
    hw_chk("hw run 2");

    start_pulse();
    txn(K_NORESP, 2'd0, 8'h2C, 8'h01, "to a");
    txn(K_NORESP, 2'd0, 8'h2C, 8'h01, "to b");
    txn(K_NORESP, 2'd0, 8'h2C, 8'h01, "to c");
    txn(K_NORESP, 2'd0, 8'h2C, 8'h01, "to d");
    k = 0;
    while (!o_error && k < 100) begin
      @(negedge clk);
      k++;
    end
    check("fail state",
          64'({o_ctrl, o_busy, o_done, o_error}),
          64'({CTRL_FAIL, 3'b001}));

    start_pulse();
    k = 1;
    while (!o_ctrl[0] && k < 50) begin
      @(negedge clk);
      k++;
    end
    check("fail restart lat", 64'(k), 64'd2);
    txn(K_ACK, 2'd0, 8'h2C, 8'h01, "rs w0");

    wait_en(2000, k);
    check("mid arm", 64'(o_ctrl[0]), 64'd1);
    repeat (3) @(negedge clk);
    sme = 1'b1;
    #2;
    rst_n = 1'b0;
    #1;
    check("mid rst",
          64'({o_ctrl, o_busy, o_done, o_error, o_step}),
          64'({32'd0, 3'b100, 2'd0}));
    @(negedge clk);
    sme = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    startup_chk("startup 2");

    txn(K_ACK, 2'd0, 8'h2C, 8'h01, "pr w0");
    txn(K_ACK, 2'd1, 8'h28, 8'h00, "pr w1");
    txn(K_ACK, 2'd2, 8'h2D, 8'h00, "pr w2");
    hw_chk("hw run 3");

    $display("Simulation finished: %0d checks, %0d errors",
             n_chk, n_err);
    $finish;
  end

endmodule
